y_row_ptr_encoder: RTL and testbench

Builds the Y-matrix row-pointer table in SRAM from a stream of non-zero element row indices. It is the write side of the row-pointer address decode path.
- Entry for row r is the index of the first non-zero of row r.
- Stored as 16-bit lane r[3:0] of the 256-bit word at address r>>4.
- An extra terminator entry at index numRows holds the total non-zero count.

The block counts elements per row, packs 16 pointers per word, and issues word writes under a valid/ready handshake to the SRAM write port.

---
 rtl/y_row_ptr_encoder_if.sv | 30 +++
 rtl/y_row_ptr_encoder.sv | 167 ++++++++++++++++
 tb/tb_y_row_ptr_encoder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/y_row_ptr_encoder_if.sv
// y_row_ptr_encoder_if
// Groups the start/finish control, the element stream handshake and the SRAM
// word-write port of the Y-matrix row-pointer encoder.
//   master: the stream source / SRAM side (drives start, elements, wrReady)
//   slave : the encoder (drives elemReady, write request, status)
interface y_row_ptr_encoder_if;
    logic         yRE_start;
    logic [15:0]  yRE_numRows;
    logic         yRE_elemValid;
    logic [15:0]  yRE_elemRow;
    logic         yRE_elemReady;
    logic         yRE_finish;
    logic         yRE_wrEn;
    logic [10:0]  yRE_wrAddr;
    logic [255:0] yRE_wrData;
    logic         yRE_wrReady;
    logic [15:0]  yRE_nnz;
    logic         yRE_err;
    logic         yRE_done;

    modport master (
        output yRE_start, yRE_numRows, yRE_elemValid, yRE_elemRow, yRE_finish, yRE_wrReady,
        input  yRE_elemReady, yRE_wrEn, yRE_wrAddr, yRE_wrData, yRE_nnz, yRE_err, yRE_done
    );

    modport slave (
        input  yRE_start, yRE_numRows, yRE_elemValid, yRE_elemRow, yRE_finish, yRE_wrReady,
        output yRE_elemReady, yRE_wrEn, yRE_wrAddr, yRE_wrData, yRE_nnz, yRE_err, yRE_done
    );
endinterface

// File: rtl/y_row_ptr_encoder.sv
// y_row_ptr_encoder
// Builds the Y-matrix row-pointer table from a non-decreasing stream of
// non-zero row indices. Entry r = index of the first non-zero of row r, packed
// as 16-bit lane r[3:0] of the 256-bit word at address r[14:4]; entry numRows
// is the terminator holding the total non-zero count.
// Ports:
//   clock - single clock, rising edge
//   reset - synchronous, active-low
//   bus   - slave side of y_row_ptr_encoder_if (control, element stream,
//           SRAM write port, nnz/err/done status)
module y_row_ptr_encoder (
    input logic               clock,
    input logic               reset,
    y_row_ptr_encoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e         state_q, state_d;
    logic [15:0]    cur_row_q, cur_row_d;    // next row whose pointer is unwritten
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    num_rows_q, num_rows_d;
    logic [15:0]    last_row_q, last_row_d;  // last accepted (non-error) row
    logic [255:0]   buf_q, buf_d;            // also drives wrData while a write is posted
    logic           wr_en_q, wr_en_d;
    logic [10:0]    wr_addr_q, wr_addr_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic [255:0]   step_buf;
    logic           step_post;
    logic           elem_bad;
    logic           elem_hit;
    logic           elem_ready;

    // Buffer as it looks after writing the current row's lane.
    always_comb begin
        step_buf = buf_q;
        step_buf[{cur_row_q[3:0], 4'b0000} +: 16] = cnt_q;
    end

    // Post the word when its last lane or the terminator has just been written.
    assign step_post = (cur_row_q[3:0] == 4'hF) || (cur_row_q == num_rows_q);

    assign elem_bad   = (bus.yRE_elemRow >= num_rows_q) || (bus.yRE_elemRow < last_row_q);
    assign elem_hit   = bus.yRE_elemRow < cur_row_q;
    assign elem_ready = (state_q == StRun) && !wr_en_q && bus.yRE_elemValid &&
                        (elem_bad || elem_hit);

    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cnt_d      = cnt_q;
        num_rows_d = num_rows_q;
        last_row_d = last_row_q;
        buf_d      = buf_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.yRE_start) begin
                    state_d    = StRun;
                    cur_row_d  = '0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    last_row_d = '0;
                    buf_d      = '1;
                    num_rows_d = bus.yRE_numRows;
                end
            end

            StRun: begin
                if (wr_en_q) begin
                    if (bus.yRE_wrReady) begin
                        wr_en_d = 1'b0;
                        buf_d   = '1;
                    end
                end else if (bus.yRE_elemValid) begin
                    if (elem_bad) begin
                        err_d = 1'b1;
                    end else if (elem_hit) begin
                        cnt_d      = cnt_q + 16'd1;
                        last_row_d = bus.yRE_elemRow;
                    end else begin
                        // Catch-up: write the pointer of one skipped row per cycle.
                        buf_d     = step_buf;
                        cur_row_d = cur_row_q + 16'd1;
                        if (step_post) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cur_row_q[14:4];
                        end
                    end
                end
                if (!bus.yRE_elemValid && bus.yRE_finish) begin
                    state_d = StFlush;
                end
            end

            StFlush: begin
                if (wr_en_q) begin
                    if (bus.yRE_wrReady) begin
                        wr_en_d = 1'b0;
                        buf_d   = '1;
                        // Terminator already written: this was the final word.
                        if (cur_row_q > num_rows_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end
                end else if (cur_row_q <= num_rows_q) begin
                    buf_d     = step_buf;
                    cur_row_d = cur_row_q + 16'd1;
                    if (step_post) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_row_q[14:4];
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            cur_row_q  <= '0;
            cnt_q      <= '0;
            num_rows_q <= '0;
            last_row_q <= '0;
            buf_q      <= '1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cnt_q      <= cnt_d;
            num_rows_q <= num_rows_d;
            last_row_q <= last_row_d;
            buf_q      <= buf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign bus.yRE_elemReady = elem_ready;
    assign bus.yRE_wrEn      = wr_en_q;
    assign bus.yRE_wrAddr    = wr_addr_q;
    assign bus.yRE_wrData    = buf_q;
    assign bus.yRE_nnz       = cnt_q;
    assign bus.yRE_err       = err_q;
    assign bus.yRE_done      = done_q;

endmodule

// File: tb/tb_y_row_ptr_encoder.sv
// tb_y_row_ptr_encoder
// Scoreboard bench: each table run pushes its expected SRAM words (from a
// behavioural row-pointer model) before stimulus; a negedge monitor pops and
// compares on every write handshake and checks stability while stalled.
module tb_y_row_ptr_encoder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    y_row_ptr_encoder_if bus ();

    y_row_ptr_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [10:0]  addr;
        logic [255:0] data;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  stall_left = 0;
    bit  rand_ready = 1'b0;

    task automatic check_val(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM ready: fixed stall count on a pending write, or random.
    initial begin
        bus.yRE_wrReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) begin
                bus.yRE_wrReady = ($urandom_range(0, 1) == 1);
            end else if (stall_left > 0 && bus.yRE_wrEn) begin
                bus.yRE_wrReady = 1'b0;
                stall_left--;
            end else begin
                bus.yRE_wrReady = 1'b1;
            end
        end
    end

    // Write monitor: handshake completes on the next rising edge.
    always @(negedge clock) begin
        if (reset && bus.yRE_wrEn) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_write", {245'd0, bus.yRE_wrAddr}, 256'd0);
            end else if (bus.yRE_wrReady) begin
                mon_e = sb_q.pop_front();
                check_val("wr_addr", {245'd0, bus.yRE_wrAddr}, {245'd0, mon_e.addr});
                check_val("wr_data", bus.yRE_wrData, mon_e.data);
            end else begin
                check_val("stall_addr", {245'd0, bus.yRE_wrAddr}, {245'd0, sb_q[0].addr});
                check_val("stall_data", bus.yRE_wrData, sb_q[0].data);
                check_val("stall_ready", {255'd0, bus.yRE_elemReady}, 256'd0);
            end
        end
    end

    // Reference: ptr[i] = number of accepted elements with row < i, i in 0..nr.
    function automatic void model(input int nr, input int rows[$],
                                  output int exp_nnz, output bit exp_err);
        int  acc[$];
        int  last;
        int  idx;
        int  c;
        wr_t e;
        last    = 0;
        exp_err = 1'b0;
        foreach (rows[i]) begin
            if (rows[i] >= nr || rows[i] < last) begin
                exp_err = 1'b1;
            end else begin
                acc.push_back(rows[i]);
                last = rows[i];
            end
        end
        exp_nnz = acc.size();
        for (int w = 0; w <= nr / 16; w++) begin
            e.addr = w[10:0];
            e.data = '1;
            for (int l = 0; l < 16; l++) begin
                idx = w * 16 + l;
                if (idx <= nr) begin
                    c = 0;
                    foreach (acc[j]) if (acc[j] < idx) c++;
                    e.data[l*16 +: 16] = c[15:0];
                end
            end
            sb_q.push_back(e);
        end
    endfunction

    task automatic start_run(input int nr);
        bus.yRE_start   = 1'b1;
        bus.yRE_numRows = nr[15:0];
        @(posedge clock);
        #1;
        bus.yRE_start = 1'b0;
    endtask

    task automatic feed(input int row);
        bit ok;
        ok = 1'b0;
        bus.yRE_elemValid = 1'b1;
        bus.yRE_elemRow   = row[15:0];
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (bus.yRE_elemReady) ok = 1'b1;
        end
        if (!ok) check_val("feed_timeout", 256'd0, 256'd1);
        @(posedge clock);
        #1;
        bus.yRE_elemValid = 1'b0;
    endtask

    task automatic finish_and_wait(input int exp_nnz, input bit exp_err);
        bit got;
        got = 1'b0;
        bus.yRE_finish = 1'b1;
        @(posedge clock);
        #1;
        bus.yRE_finish = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clock);
            if (bus.yRE_done) got = 1'b1;
        end
        check_val("done_seen", {255'd0, got}, 256'd1);
        check_val("nnz", {240'd0, bus.yRE_nnz}, {240'd0, exp_nnz[15:0]});
        check_val("err", {255'd0, bus.yRE_err}, {255'd0, exp_err});
        check_val("sb_drained", 256'(sb_q.size()), 256'd0);
        @(negedge clock);
        check_val("done_pulse", {255'd0, bus.yRE_done}, 256'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input int nr, input int rows[$], input int stall);
        int en;
        bit ee;
        model(nr, rows, en, ee);
        stall_left = stall;
        start_run(nr);
        foreach (rows[i]) feed(rows[i]);
        finish_and_wait(en, ee);
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_wren"}, {255'd0, bus.yRE_wrEn}, 256'd0);
        check_val({pfx, "_wraddr"}, {245'd0, bus.yRE_wrAddr}, 256'd0);
        check_val({pfx, "_wrdata"}, bus.yRE_wrData, '1);
        check_val({pfx, "_ready"}, {255'd0, bus.yRE_elemReady}, 256'd0);
        check_val({pfx, "_nnz"}, {240'd0, bus.yRE_nnz}, 256'd0);
        check_val({pfx, "_err"}, {255'd0, bus.yRE_err}, 256'd0);
        check_val({pfx, "_done"}, {255'd0, bus.yRE_done}, 256'd0);
    endtask

    initial begin
        int q[$];
        int en;
        bit ee;
        bit got;
        int nr;
        int r;
        int n;

        bus.yRE_start     = 1'b0;
        bus.yRE_numRows   = '0;
        bus.yRE_elemValid = 1'b0;
        bus.yRE_elemRow   = '0;
        bus.yRE_finish    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Rows {0,0,2}, numRows=3: lanes 0,2,2,3.
        q = {0, 0, 2};
        run_table(3, q, 0);

        // One element per row 0..19, first word held off for 5 cycles.
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(i);
        run_table(20, q, 5);

        // No elements, numRows=16: two words, terminator in word 1.
        q = {};
        run_table(16, q, 0);

        // Out-of-order and out-of-range elements are dropped.
        q = {5, 3, 40};
        run_table(10, q, 0);

        // Reset while a write is pending.
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(i);
        model(20, q, en, ee);
        stall_left = 1000;
        start_run(20);
        for (int i = 0; i < 15; i++) feed(i);
        bus.yRE_elemValid = 1'b1;
        bus.yRE_elemRow   = 16'd15;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (bus.yRE_wrEn) got = 1'b1;
        end
        check_val("rst_pending_wren", {255'd0, got}, 256'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.yRE_elemValid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        stall_left = 0;
        sb_q.delete();
        @(negedge clock);
        check_reset_values("abort");
        @(posedge clock);
        #1;
        q = {1, 1, 4};
        run_table(5, q, 0);

        // Random tables with random SRAM back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            nr = $urandom_range(1, 60);
            n  = $urandom_range(3, 40);
            r  = 0;
            q  = {};
            for (int i = 0; i < n; i++) begin
                r = r + $urandom_range(0, 2);
                if ($urandom_range(0, 9) == 0) q.push_back(nr + 3);
                else if ($urandom_range(0, 9) == 0 && r >= 2) q.push_back(r - 2);
                else q.push_back(r);
            end
            run_table(nr, q, 0);
        end
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
